// File: rtl/intr_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : intr_timer_ctrl_pkg
// Brief    : Register map, privilege encodings and reset constants shared by
//            the machine timer / external interrupt block.
// Revision : 1.0 - initial release
// ============================================================================
package intr_timer_ctrl_pkg;

    localparam logic [2:0] INTR_ADR_MTIME_LO    = 3'd0;
    localparam logic [2:0] INTR_ADR_MTIME_HI    = 3'd1;
    localparam logic [2:0] INTR_ADR_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] INTR_ADR_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] INTR_ADR_CTRL        = 3'd4;
    localparam logic [2:0] INTR_ADR_IRQ_PEND    = 3'd5;
    localparam logic [2:0] INTR_ADR_IRQ_RAW     = 3'd6;

    typedef enum logic [1:0] {
        U_MODE = 2'b00,
        S_MODE = 2'b01,
        M_MODE = 2'b11
    } priv_e;

    // mtimecmp resets to the maximum so no compare hit fires before software programs it
    localparam logic [63:0] INTR_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/intr_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : intr_timer_ctrl_if
// Brief    : Word-addressed register I/O port between the load/store unit
//            (master) and the timer/interrupt block (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface intr_timer_ctrl_if;
    import intr_timer_ctrl_pkg::*;

    logic        we;
    logic [2:0]  wadr;
    logic [31:0] wdata;
    logic        re;
    logic [2:0]  radr;
    logic [31:0] rdata;

    modport master (
        output we, wadr, wdata, re, radr,
        input  rdata
    );

    modport slave (
        input  we, wadr, wdata, re, radr,
        output rdata
    );

endinterface
`default_nettype wire

// File: rtl/intr_timer_ctrl_irq_sync.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync
// Brief    : STAGES-deep synchronizer for an asynchronous interrupt line plus
//            a rising-edge detector on the synchronized level.
// Revision : 1.0 - initial release
// ============================================================================
module irq_sync
    import intr_timer_ctrl_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_async,
    output logic      o_sync,
    output logic      o_rise
);

    logic [STAGES-1:0] r_chain;
    logic              r_sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain  <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_chain  <= {r_chain[STAGES-2:0], i_async};
            r_sync_d <= r_chain[STAGES-1];
        end
    end

    assign o_sync = r_chain[STAGES-1];
    assign o_rise = r_chain[STAGES-1] & ~r_sync_d;

endmodule
`default_nettype wire

// File: rtl/intr_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : intr_timer_ctrl
// Brief    : Machine timer (mtime/mtimecmp + prescaler) and external interrupt
//            pending latch feeding the CSR file. Define INTR_EXT_LEVEL_EN to
//            make the external interrupt level-sensitive instead of latched.
// Revision : 1.0 - initial release
// ============================================================================
module intr_timer_ctrl
    import intr_timer_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PRESC_W     = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    intr_timer_ctrl_if.slave   io,
    input  wire logic          ext_irq,
    input  wire logic          csr_meie,
    input  wire logic          csr_mtie,
    output logic               g_interrupt,
    output logic               g_interrupt_1shot,
    output logic [1:0]         g_interrupt_priv,
    output logic               frc_cntr_val_leq
);

    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp;
    logic               r_tm_en;
    logic [PRESC_W-1:0] r_prescale;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic               r_leq;
    logic               r_irq_d;
    logic [31:0]        r_rdata;

    logic               w_wr_mtime_lo;
    logic               w_wr_mtime_hi;
    logic               w_wr_cmp_lo;
    logic               w_wr_cmp_hi;
    logic               w_wr_ctrl;
    logic               w_tick;
    logic               w_sync;
    logic               w_rise;
    logic               w_pending;
    logic [31:0]        w_ctrl_word;
    logic [31:0]        w_rd_val;

    assign w_wr_mtime_lo = io.we && (io.wadr == INTR_ADR_MTIME_LO);
    assign w_wr_mtime_hi = io.we && (io.wadr == INTR_ADR_MTIME_HI);
    assign w_wr_cmp_lo   = io.we && (io.wadr == INTR_ADR_MTIMECMP_LO);
    assign w_wr_cmp_hi   = io.we && (io.wadr == INTR_ADR_MTIMECMP_HI);
    assign w_wr_ctrl     = io.we && (io.wadr == INTR_ADR_CTRL);

    assign w_tick = r_tm_en && (r_presc_cnt == r_prescale);

    // Prescaler and control register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tm_en     <= 1'b0;
            r_prescale  <= '0;
            r_presc_cnt <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_tm_en    <= io.wdata[0];
                r_prescale <= io.wdata[8 +: PRESC_W];
            end
            if (w_wr_ctrl) begin
                r_presc_cnt <= '0;
            end else if (r_tm_en) begin
                r_presc_cnt <= w_tick ? '0 : r_presc_cnt + 1'b1;
            end
        end
    end

    // A software write to either half takes priority over the tick and suppresses carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtime <= '0;
        end else if (w_wr_mtime_lo) begin
            r_mtime[31:0] <= io.wdata;
        end else if (w_wr_mtime_hi) begin
            r_mtime[63:32] <= io.wdata;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtimecmp <= INTR_MTIMECMP_RST;
            r_leq      <= 1'b0;
        end else begin
            if (w_wr_cmp_lo) begin
                r_mtimecmp[31:0] <= io.wdata;
            end
            if (w_wr_cmp_hi) begin
                r_mtimecmp[63:32] <= io.wdata;
            end
            r_leq <= (r_mtimecmp <= r_mtime);
        end
    end

    irq_sync #(
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (ext_irq),
        .o_sync  (w_sync),
        .o_rise  (w_rise)
    );

`ifdef INTR_EXT_LEVEL_EN
    assign w_pending = w_sync;
`else
    logic r_pending;
    logic w_clr;

    assign w_clr = io.we && (io.wadr == INTR_ADR_IRQ_PEND) && io.wdata[0];

    // A fresh edge outranks a coincident software clear so no interrupt is lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (w_rise) begin
            r_pending <= 1'b1;
        end else if (w_clr) begin
            r_pending <= 1'b0;
        end
    end

    assign w_pending = r_pending;
`endif

    assign g_interrupt       = w_pending & csr_meie;
    assign g_interrupt_1shot = g_interrupt & ~r_irq_d;
    assign g_interrupt_priv  = M_MODE;
    assign frc_cntr_val_leq  = r_leq & csr_mtie & r_tm_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_d <= 1'b0;
        end else begin
            r_irq_d <= g_interrupt;
        end
    end

    always_comb begin
        w_ctrl_word               = '0;
        w_ctrl_word[0]            = r_tm_en;
        w_ctrl_word[8 +: PRESC_W] = r_prescale;
    end

    always_comb begin
        w_rd_val = '0;
        case (io.radr)
            INTR_ADR_MTIME_LO:    w_rd_val = r_mtime[31:0];
            INTR_ADR_MTIME_HI:    w_rd_val = r_mtime[63:32];
            INTR_ADR_MTIMECMP_LO: w_rd_val = r_mtimecmp[31:0];
            INTR_ADR_MTIMECMP_HI: w_rd_val = r_mtimecmp[63:32];
            INTR_ADR_CTRL:        w_rd_val = w_ctrl_word;
            INTR_ADR_IRQ_PEND:    w_rd_val = {31'b0, w_pending};
            INTR_ADR_IRQ_RAW:     w_rd_val = {31'b0, w_sync};
            default:              w_rd_val = '0;
        endcase
    end

    // Reads sample pre-write state, so a same-cycle write to the address is not observed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (io.re) begin
            r_rdata <= w_rd_val;
        end
    end

    assign io.rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_intr_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_intr_timer_ctrl
// Brief    : Self-checking bench: register vector table plus timer, carry and
//            external interrupt sequences, with a read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intr_timer_ctrl;
    import intr_timer_ctrl_pkg::*;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ext_irq  = 1'b0;
    logic       csr_meie = 1'b0;
    logic       csr_mtie = 1'b0;
    logic       g_interrupt;
    logic       g_interrupt_1shot;
    logic [1:0] g_interrupt_priv;
    logic       frc_cntr_val_leq;

    int vectors     = 0;
    int miscompares = 0;

    intr_timer_ctrl_if io ();

    intr_timer_ctrl #(
        .SYNC_STAGES (2),
        .PRESC_W     (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .io                (io),
        .ext_irq           (ext_irq),
        .csr_meie          (csr_meie),
        .csr_mtie          (csr_mtie),
        .g_interrupt       (g_interrupt),
        .g_interrupt_1shot (g_interrupt_1shot),
        .g_interrupt_priv  (g_interrupt_priv),
        .frc_cntr_val_leq  (frc_cntr_val_leq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [2:0]  adr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t vt[$];
    sb_t  sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        io.we    = 1'b1;
        io.wadr  = a;
        io.wdata = d;
        step();
        io.we    = 1'b0;
    endtask

    task automatic rd_issue(input logic [2:0] a, input logic [31:0] exp, input string name);
        sb_q.push_back('{name, exp});
        io.re   = 1'b1;
        io.radr = a;
    endtask

    task automatic rd_collect();
        sb_t e;
        io.re = 1'b0;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.name, io.rdata, e.exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        rd_issue(a, exp, name);
        step();
        rd_collect();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        io.we = 1'b0; io.wadr = '0; io.wdata = '0;
        io.re = 1'b0; io.radr = '0;

        step();
        step();
        check("rst_rdata",  io.rdata,                 32'h0);
        check("rst_gint",   {31'b0, g_interrupt},     32'h0);
        check("rst_1shot",  {31'b0, g_interrupt_1shot}, 32'h0);
        check("rst_leq",    {31'b0, frc_cntr_val_leq}, 32'h0);
        check("rst_priv",   {30'b0, g_interrupt_priv}, 32'h3);
        rst_n = 1'b1;
        step();

        // register map table, timer disabled throughout
        vt.push_back('{1'b0, 3'd0, 32'h0,          32'h0000_0000, "rd_mtime_lo_rst"});
        vt.push_back('{1'b0, 3'd1, 32'h0,          32'h0000_0000, "rd_mtime_hi_rst"});
        vt.push_back('{1'b0, 3'd2, 32'h0,          32'hFFFF_FFFF, "rd_cmp_lo_rst"});
        vt.push_back('{1'b0, 3'd3, 32'h0,          32'hFFFF_FFFF, "rd_cmp_hi_rst"});
        vt.push_back('{1'b0, 3'd4, 32'h0,          32'h0000_0000, "rd_ctrl_rst"});
        vt.push_back('{1'b0, 3'd5, 32'h0,          32'h0000_0000, "rd_pend_rst"});
        vt.push_back('{1'b0, 3'd6, 32'h0,          32'h0000_0000, "rd_raw_rst"});
        vt.push_back('{1'b0, 3'd7, 32'h0,          32'h0000_0000, "rd_adr7_rst"});
        vt.push_back('{1'b1, 3'd2, 32'h1234_5678,  32'h0,         "wr_cmp_lo"});
        vt.push_back('{1'b0, 3'd2, 32'h0,          32'h1234_5678, "rd_cmp_lo"});
        vt.push_back('{1'b1, 3'd3, 32'h0000_00AB,  32'h0,         "wr_cmp_hi"});
        vt.push_back('{1'b0, 3'd3, 32'h0,          32'h0000_00AB, "rd_cmp_hi"});
        vt.push_back('{1'b1, 3'd4, 32'h0000_0700,  32'h0,         "wr_ctrl"});
        vt.push_back('{1'b0, 3'd4, 32'h0,          32'h0000_0700, "rd_ctrl"});
        vt.push_back('{1'b1, 3'd4, 32'hFFFF_FFFE,  32'h0,         "wr_ctrl_mask"});
        vt.push_back('{1'b0, 3'd4, 32'h0,          32'h0000_FF00, "rd_ctrl_mask"});
        vt.push_back('{1'b1, 3'd7, 32'hA5A5_A5A5,  32'h0,         "wr_adr7"});
        vt.push_back('{1'b0, 3'd7, 32'h0,          32'h0000_0000, "rd_adr7"});
        vt.push_back('{1'b1, 3'd0, 32'hDEAD_BEEF,  32'h0,         "wr_mtime_lo"});
        vt.push_back('{1'b0, 3'd0, 32'h0,          32'hDEAD_BEEF, "rd_mtime_lo"});
        vt.push_back('{1'b1, 3'd1, 32'hCAFE_F00D,  32'h0,         "wr_mtime_hi"});
        vt.push_back('{1'b0, 3'd1, 32'h0,          32'hCAFE_F00D, "rd_mtime_hi"});
        vt.push_back('{1'b1, 3'd6, 32'h0000_0001,  32'h0,         "wr_raw"});
        vt.push_back('{1'b0, 3'd6, 32'h0,          32'h0000_0000, "rd_raw_ro"});
        vt.push_back('{1'b0, 3'd0, 32'h0,          32'hDEAD_BEEF, "rd_mtime_held"});

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].wr) wr(vt[i].adr, vt[i].data);
            else          rd(vt[i].adr, vt[i].exp, vt[i].name);
        end
        check("leq_gated_tm_en", {31'b0, frc_cntr_val_leq}, 32'h0);

        // read/write same address same cycle returns the old value
        io.we = 1'b1; io.wadr = 3'd2; io.wdata = 32'h0BAD_0BAD;
        rd_issue(3'd2, 32'h1234_5678, "rd_during_wr");
        step();
        io.we = 1'b0;
        rd_collect();

        // prescale 3: mtime = k after 4k edges, compare hit at mtime 5
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h0);
        wr(3'd2, 32'h5);
        wr(3'd3, 32'h0);
        csr_mtie = 1'b1;
        wr(3'd4, 32'h0000_0301);
        for (int i = 1; i <= 24; i++) begin
            step();
            if (i == 20 || i == 21 || i == 24)
                check($sformatf("leq_cycle_%0d", i), {31'b0, frc_cntr_val_leq}, {31'b0, i >= 21});
            if (i == 8) rd_issue(3'd0, 32'd2, "rd_mtime_presc");
            if (i == 9) rd_collect();
        end
        csr_mtie = 1'b0;
        #1;
        check("leq_mtie_off", {31'b0, frc_cntr_val_leq}, 32'h0);
        csr_mtie = 1'b1;
        #1;
        check("leq_mtie_on", {31'b0, frc_cntr_val_leq}, 32'h1);
        wr(3'd4, 32'h0);
        check("leq_tm_dis", {31'b0, frc_cntr_val_leq}, 32'h0);
        rd(3'd0, 32'd6, "rd_mtime_after_run");

        // 32-bit carry into the upper half
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd1, 32'h0);
        wr(3'd4, 32'h1);
        wr(3'd4, 32'h0);
        rd(3'd0, 32'h0, "carry_lo");
        rd(3'd1, 32'h1, "carry_hi");

        // write to hi overrides the tick without carry, next tick carries
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd1, 32'h0);
        wr(3'd4, 32'h1);
        wr(3'd1, 32'h7);
        wr(3'd4, 32'h0);
        rd(3'd0, 32'h0, "override_lo");
        rd(3'd1, 32'h8, "override_hi");

        // all-ones wraps to zero
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd4, 32'h1);
        wr(3'd4, 32'h0);
        rd(3'd0, 32'h0, "wrap_lo");
        rd(3'd1, 32'h0, "wrap_hi");

        // external interrupt: pending two edges after the rise, single 1shot
        csr_meie = 1'b1;
        ext_irq  = 1'b1;
        step();
        check("ext_e0_gint", {31'b0, g_interrupt}, 32'h0);
        step();
        check("ext_e1_gint", {31'b0, g_interrupt}, 32'h0);
        step();
        check("ext_e2_gint",  {31'b0, g_interrupt},       32'h1);
        check("ext_e2_1shot", {31'b0, g_interrupt_1shot}, 32'h1);
        step();
        check("ext_e3_gint",  {31'b0, g_interrupt},       32'h1);
        check("ext_e3_1shot", {31'b0, g_interrupt_1shot}, 32'h0);
        ext_irq = 1'b0;
        rd(3'd6, 32'h1, "rd_raw_high");
        rd(3'd5, 32'h1, "rd_pend_set");
        wr(3'd5, 32'h1);
        check("clr_gint", {31'b0, g_interrupt}, 32'h0);
        rd(3'd5, 32'h0, "rd_pend_clr");

        // clear coincident with a new rising edge: set wins
        repeat (3) step();
        ext_irq = 1'b1;
        step();
        step();
        wr(3'd5, 32'h1);
        check("set_wins_gint", {31'b0, g_interrupt}, 32'h1);
        rd(3'd5, 32'h1, "set_wins_pend");
        ext_irq = 1'b0;

        // enable gating and a fresh 1shot on meie re-enable
        csr_meie = 1'b0;
        #1;
        check("meie_off_gint",  {31'b0, g_interrupt},       32'h0);
        check("meie_off_1shot", {31'b0, g_interrupt_1shot}, 32'h0);
        step();
        step();
        csr_meie = 1'b1;
        #1;
        check("meie_on_gint",  {31'b0, g_interrupt},       32'h1);
        check("meie_on_1shot", {31'b0, g_interrupt_1shot}, 32'h1);
        step();
        check("meie_on_1shot_end", {31'b0, g_interrupt_1shot}, 32'h0);

        // asynchronous reset mid-count and mid-pending
        wr(3'd4, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gint",  {31'b0, g_interrupt}, 32'h0);
        check("arst_rdata", io.rdata,             32'h0);
        check("arst_priv",  {30'b0, g_interrupt_priv}, 32'h3);
        step();
        rst_n = 1'b1;
        step();
        rd(3'd4, 32'h0,         "arst_ctrl");
        rd(3'd2, 32'hFFFF_FFFF, "arst_cmp_lo");
        rd(3'd0, 32'h0,         "arst_mtime_lo");
        rd(3'd5, 32'h0,         "arst_pend");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/intr_timer_ctrl.md
# intr_timer_ctrl

Machine-mode interrupt source block that sits directly upstream of the CSR register file. It owns the 64-bit machine timer (mtime/mtimecmp with prescaler) and the external interrupt synchronizer/pending latch. It produces the interrupt request, one-shot, privilege and timer-compare signals that the CSR file consumes. Its registers are accessed by the load/store unit over a simple word-addressed I/O port.

## Interface
- SYNC_STAGES, 2: external interrupt synchronizer depth (≥2)
- PRESC_W, 8: prescaler width
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- io_we  in  1  register write strobe
- io_wadr  in  3  write word address
- io_wdata  in  32  write data
- io_re  in  1  register read strobe
- io_radr  in  3  read word address
- io_rdata  out  32  read data, registered
- ext_irq  in  1  asynchronous external interrupt line, active high
- csr_meie  in  1  external interrupt enable from CSR mie[11]
- csr_mtie  in  1  timer interrupt enable from CSR mie[7]
- g_interrupt  out  1  external interrupt request (pending & csr_meie)
- g_interrupt_1shot  out  1  one-cycle pulse on rising edge of g_interrupt
- g_interrupt_priv  out  2  target privilege, constant 2'b11 (M-mode)
- frc_cntr_val_leq  out  1  timer compare hit (mtimecmp ≤ mtime) & csr_mtie & tm_en

## Operation
- Register map (word address):
  - 0: mtime[31:0]
  - 1: mtime[63:32]
  - 2: mtimecmp[31:0]
  - 3: mtimecmp[63:32]
  - 4: ctrl — [0] tm_en, [15:8] prescale
  - 5: irq_pend — [0] pending, write 1 to clear
  - 6: irq_raw — [0] synchronized ext_irq, read-only
  - 7: reads 0
- Reset values: mtime 0; mtimecmp 64'hFFFF_FFFF_FFFF_FFFF; ctrl 0; pending 0; synchronizer 0; io_rdata 0; all outputs 0 except g_interrupt_priv = 2'b11.
- Prescaler:
  - presc_cnt counts 0..prescale while tm_en = 1.
  - At presc_cnt == prescale: presc_cnt → 0 and mtime += 1, i.e. one mtime tick per prescale+1 cycles.
  - tm_en = 0 holds both presc_cnt and mtime.
  - A write to ctrl clears presc_cnt.
- mtime is a full 64-bit increment; carry propagates lo→hi; all-ones wraps to 0.
- A write to mtime lo or hi overrides the increment in that cycle; only the written half changes and no carry is applied that cycle.
- Compare: leq_r registered each cycle as (mtimecmp ≤ mtime, unsigned 64-bit); frc_cntr_val_leq = leq_r & csr_mtie & tm_en. The level holds until software moves mtimecmp or mtime.
- External interrupt:
  - SYNC_STAGES flip-flop chain, then sync_d delay register.
  - Rising edge (sync & ~sync_d) sets pending.
  - A clear write (addr 5, bit0 = 1) in the same cycle as a set: set wins.
- g_interrupt = pending & csr_meie. irq_d registers g_interrupt; g_interrupt_1shot = g_interrupt & ~irq_d.
- Reads: io_rdata updates on the edge after io_re with the addressed value, and holds otherwise. A read and a write to the same address in the same cycle return the pre-write value.

## Timing
- Read latency: 1 cycle.
- Write effect: visible in the register on the next edge.
- ext_irq rising before edge 0 (SYNC_STAGES = 2):
  - sync high after edge 1.
  - pending and g_interrupt high after edge 2.
  - g_interrupt_1shot high for exactly the cycle following edge 2.
- Timer: mtime reaching mtimecmp at edge N → frc_cntr_val_leq high after edge N+1.
- csr_meie / csr_mtie changes affect the outputs combinationally. A meie 0→1 with pending set generates a new 1shot.
- Reset mid-count or mid-pending returns all state to reset values asynchronously.

## Configuration
- INTR_EXT_LEVEL_EN:
  - Defined: pending is replaced by the level of the synchronized ext_irq; clear writes are ignored; irq_pend reads the synchronized level.
  - Undefined (default): edge-triggered latched pending as described above.

## Structure
- Shared package holds: register address constants (INTR_ADR_MTIME_LO … INTR_ADR_IRQ_RAW), the M_MODE/S_MODE/U_MODE privilege constants, and the mtimecmp reset constant.
- One sub-module: irq_sync (parameterized SYNC_STAGES synchronizer plus rising-edge detector), reusable for future interrupt lines.

## Test plan
- Reset, then read addr 2/3 → 32'hFFFF_FFFF each; frc_cntr_val_leq = 0; g_interrupt_priv = 2'b11.
- ctrl = 32'h0000_0301 (prescale 3, enable), mtimecmp = 5, csr_mtie = 1 → mtime increments every 4 cycles; frc_cntr_val_leq rises 1 cycle after mtime = 5.
- mtime = 64'h0000_0000_FFFF_FFFF, prescale 0 → after 1 tick, reads give lo 0, hi 1; all-ones wraps to 0.
- ext_irq pulse with csr_meie = 1 → g_interrupt high 2 edges later; 1shot exactly 1 cycle; write addr 5 = 1 → g_interrupt drops next cycle.
- Clear write coincident with a new rising edge → pending remains 1.
- csr_meie = 0 with pending = 1 → g_interrupt = 0; then csr_meie = 1 → g_interrupt and one 1shot pulse.
